mc_control_fsm: RTL and testbench
=================================

# mc_control_fsm

Multicycle sequencing controller for the MIPS core's shared-memory, single-ALU datapath variant. It walks each instruction through fetch, decode, execute, memory and writeback states, one state per cycle. It stalls in memory states until memory acknowledges, and drives every datapath enable and mux select. It sits beside the datapath in `src/processor/controller` and supports the same six opcodes as the main decoder: RTYPE, LW, SW, BEQ, ADDI, J.

## Interface
Parameters:
- none; opcode and state encodings come from the shared package.

Ports:
- `clk`  in  1  — single clock, rising-edge.
- `rst`  in  1  — synchronous, active-high reset.
- `opcode`  in  6  — instruction register bits [31:26], valid from DECODE onward.
- `zero`  in  1  — ALU zero flag.
- `mem_ready`  in  1  — memory acknowledge; completes the current access this cycle.
- `mem_req`  out  1  — memory access request.
- `iord`  out  1  — address select: 0 = PC, 1 = ALUOut.
- `ir_write`  out  1  — instruction register load.
- `pc_write`  out  1  — unconditional PC write.
- `branch`  out  1  — conditional branch qualifier.
- `pc_en`  out  1  — equals `pc_write | (branch & zero)`.
- `pc_src`  out  2  — 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `alu_src_a`  out  1  — 0 = PC, 1 = register A.
- `alu_src_b`  out  2  — 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate<<2.
- `alu_op`  out  2  — 00 = add, 01 = sub, 10 = use funct.
- `reg_write`  out  1  — register file write.
- `reg_dest`  out  1  — 1 = rd, 0 = rt.
- `mem_to_reg`  out  1  — 1 = memory data, 0 = ALUOut.
- `mem_write`  out  1  — memory write strobe.
- `instr_done`  out  1  — one-cycle pulse in the last state of each instruction.
- `state`  out  4  — current state, for debug and the bench.

## Operation
The state register resets to FETCH. Outputs are Moore decodes of state; the only exceptions are `ir_write` and `pc_write` in FETCH, which are qualified by `mem_ready`. Any output not listed for a state is 0.

States, their active outputs, and next-state rules:
- FETCH: `mem_req`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=00, `pc_src`=00, `ir_write`=`pc_write`=`mem_ready`. Goes to DECODE when `mem_ready`, otherwise stays.
- DECODE: `alu_src_a`=0, `alu_src_b`=11, `alu_op`=00. Next state by opcode: LW/SW → MEMADR; RTYPE → EXECUTE; BEQ → BRANCH; ADDI → ADDIEX; J → JUMP.
- Unknown opcodes are decoded as RTYPE and go to EXECUTE.
- MEMADR: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00. Goes to MEMREAD for LW, MEMWR for SW.
- MEMREAD: `mem_req`=1, `iord`=1. Goes to MEMWB on `mem_ready`, otherwise stays.
- MEMWB: `reg_write`=1, `reg_dest`=0, `mem_to_reg`=1, `instr_done`=1. Goes to FETCH.
- MEMWR: `mem_req`=1, `iord`=1, `mem_write`=1, `instr_done`=`mem_ready`. Goes to FETCH on `mem_ready`, otherwise stays.
- EXECUTE: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10. Goes to ALUWB.
- ALUWB: `reg_write`=1, `reg_dest`=1, `mem_to_reg`=0, `instr_done`=1. Goes to FETCH.
- BRANCH: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `pc_src`=01, `branch`=1, `instr_done`=1. Goes to FETCH.
- ADDIEX: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00. Goes to ADDIWB.
- ADDIWB: `reg_write`=1, `reg_dest`=0, `mem_to_reg`=0, `instr_done`=1. Goes to FETCH.
- JUMP: `pc_src`=10, `pc_write`=1, `instr_done`=1. Goes to FETCH.

## Timing
- Cycle counts with `mem_ready` tied high: LW 5, SW 4, RTYPE 4, ADDI 4, BEQ 3, J 3.
- Each cycle of `mem_ready`=0 in FETCH, MEMREAD or MEMWR adds one cycle. Outputs are held constant while stalled.
- `opcode` is sampled only in DECODE and MEMADR. Changes at any other time are ignored.
- `rst`=1 at a clock edge puts the state in FETCH on that edge. This holds mid-instruction and mid-stall, and pending writes are abandoned.
- While `rst` is high, all outputs are forced to 0, including `mem_req`. FETCH outputs resume on the first cycle after `rst` falls.
- `mem_ready` is ignored in states that do not assert `mem_req`.
- `zero` affects `pc_en` only in BRANCH, combinationally in the same cycle.

## Structure
- Package `mc_control_pkg`, shared by the controller and the bench:
  - `state_t` enum, 4-bit, FETCH=0 … JUMP=11;
  - opcode localparams (RTYPE, LW, SW, BEQ, ADDI, JUMP);
  - `alu_op` encodings (ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT);
  - `alu_src_b` and `pc_src` encodings.
- Sub-module `mc_control_outdec`: a purely combinational map from `state_t` plus `mem_ready` to the control word.
- Top level contains the state register, the next-state logic, `pc_en`, and the reset gating.

## Test plan
- LW, `mem_ready`=1: states 0,1,2,3,4. `reg_write`=`mem_to_reg`=1 in cycle 5. `instr_done` pulses once.
- SW with `mem_ready` low for 2 cycles in MEMWR: the block stays 3 cycles in MEMWR with `mem_write`=1 throughout. `instr_done` fires only on the ready cycle; the instruction takes 6 cycles total.
- FETCH with `mem_ready` low for 3 cycles, then high: `ir_write`/`pc_write` are 0, 0, 0, then 1 (exactly one pulse), and the next state is DECODE.
- BEQ: with `zero`=1, `pc_en`=1 and `pc_src`=01 in BRANCH. With `zero`=0, `pc_en`=0. Both cases take 3 cycles.
- J, then opcode 6'b111111: J takes 3 cycles with `pc_src`=10. The unknown opcode follows the RTYPE path, EXECUTE then ALUWB with `reg_dest`=1.
- `rst` asserted in MEMREAD: all outputs are 0 while reset is held. FETCH with `mem_req`=1 appears on the cycle after release, and no `reg_write` occurs.

Source files
------------

// File: rtl/mc_control_pkg.sv
// Shared encodings for the multicycle controller: state enum, opcodes,
// datapath select codes and the packed control word.
package mc_control_pkg;

  localparam int unsigned STATE_W  = 4;
  localparam int unsigned OPCODE_W = 6;

  typedef enum logic [STATE_W-1:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMREAD = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JUMP    = 4'd11
  } state_t;

  // Opcodes (instruction bits [31:26]); prefixed to avoid clashing with state names
  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'h23;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'h2b;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OPCODE_W-1:0] OP_JUMP  = 6'h02;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       mem_req;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       branch;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       reg_dest;
    logic       mem_to_reg;
    logic       mem_write;
    logic       instr_done;
  } ctrl_t;

endpackage

// File: rtl/mc_control_if.sv
// Controller <-> datapath/memory bundle.
// master: controller side (takes opcode/zero/mem_ready, drives all controls).
// slave : datapath/memory side.
interface mc_control_if;
  import mc_control_pkg::*;

  logic [OPCODE_W-1:0] opcode;
  logic                zero;
  logic                mem_ready;

  logic       mem_req;
  logic       iord;
  logic       ir_write;
  logic       pc_write;
  logic       branch;
  logic       pc_en;
  logic [1:0] pc_src;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       reg_write;
  logic       reg_dest;
  logic       mem_to_reg;
  logic       mem_write;
  logic       instr_done;
  state_t     state;

  modport master (
    input  opcode, zero, mem_ready,
    output mem_req, iord, ir_write, pc_write, branch, pc_en, pc_src,
           alu_src_a, alu_src_b, alu_op, reg_write, reg_dest, mem_to_reg,
           mem_write, instr_done, state
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  mem_req, iord, ir_write, pc_write, branch, pc_en, pc_src,
           alu_src_a, alu_src_b, alu_op, reg_write, reg_dest, mem_to_reg,
           mem_write, instr_done, state
  );
endinterface

// File: rtl/mc_control_outdec.sv
// Combinational control-word decode of the current state.
// Ports: state (current state), mem_ready (qualifies FETCH loads and MEMWR done),
//        ctrl (control word; unlisted fields are 0).
module mc_control_outdec
  import mc_control_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (state)
      FETCH: begin
        ctrl.mem_req   = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_src    = PCSRC_ALU;
        // IR and PC load only on the cycle memory actually returns the word
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      DECODE: begin
        ctrl.alu_src_b = SRCB_IMMSH;
        ctrl.alu_op    = ALUOP_ADD;
      end
      MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      MEMREAD: begin
        ctrl.mem_req = 1'b1;
        ctrl.iord    = 1'b1;
      end
      MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      MEMWR: begin
        ctrl.mem_req    = 1'b1;
        ctrl.iord       = 1'b1;
        ctrl.mem_write  = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      EXECUTE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      ALUWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dest   = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      BRANCH: begin
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_src_b  = SRCB_REG;
        ctrl.alu_op     = ALUOP_SUB;
        ctrl.pc_src     = PCSRC_ALUOUT;
        ctrl.branch     = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      ADDIWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      JUMP: begin
        ctrl.pc_src     = PCSRC_JUMP;
        ctrl.pc_write   = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS sequencing controller (FETCH..writeback, memory stalls).
// Ports: clk, rst (sync active-high), bus (mc_control_if.master: opcode, zero,
//        mem_ready in; all datapath enables/selects, pc_en, instr_done, state out).
module mc_control_fsm
  import mc_control_pkg::*;
(
  input logic          clk,
  input logic          rst,
  mc_control_if.master bus
);

  state_t state_q;
  state_t state_d;
  ctrl_t  word;
  ctrl_t  gated;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  // Next-state logic; opcode is only looked at in DECODE and MEMADR
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH:   if (bus.mem_ready) state_d = DECODE;
      DECODE: begin
        unique case (bus.opcode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEX;
          OP_JUMP:      state_d = JUMP;
          default:      state_d = EXECUTE;  // RTYPE and unknown opcodes
        endcase
      end
      MEMADR:  state_d = (bus.opcode == OP_SW) ? MEMWR : MEMREAD;
      MEMREAD: if (bus.mem_ready) state_d = MEMWB;
      MEMWR:   if (bus.mem_ready) state_d = FETCH;
      EXECUTE: state_d = ALUWB;
      ADDIEX:  state_d = ADDIWB;
      MEMWB, ALUWB, BRANCH, ADDIWB, JUMP: state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  mc_control_outdec u_outdec (
    .state     (state_q),
    .mem_ready (bus.mem_ready),
    .ctrl      (word)
  );

  // Output stage: everything is held at 0 while reset is asserted
  always_comb begin
    gated = '0;
    if (!rst) gated = word;
  end

  assign bus.mem_req    = gated.mem_req;
  assign bus.iord       = gated.iord;
  assign bus.ir_write   = gated.ir_write;
  assign bus.pc_write   = gated.pc_write;
  assign bus.branch     = gated.branch;
  assign bus.pc_src     = gated.pc_src;
  assign bus.alu_src_a  = gated.alu_src_a;
  assign bus.alu_src_b  = gated.alu_src_b;
  assign bus.alu_op     = gated.alu_op;
  assign bus.reg_write  = gated.reg_write;
  assign bus.reg_dest   = gated.reg_dest;
  assign bus.mem_to_reg = gated.mem_to_reg;
  assign bus.mem_write  = gated.mem_write;
  assign bus.instr_done = gated.instr_done;
  assign bus.pc_en      = gated.pc_write | (gated.branch & bus.zero);
  assign bus.state      = rst ? FETCH : state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: walks each instruction class cycle by
// cycle against hand-written state sequences and output expectations.
module tb_mc_control_fsm;
  import mc_control_pkg::*;

  localparam int unsigned MAXC = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mc_control_if bus ();

  mc_control_fsm dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Per-cycle stimulus / expected-state tables filled by each test
  int unsigned  exp_state [MAXC];
  logic         rdy_seq   [MAXC];
  logic [5:0]   op_seq    [MAXC];

  // Per-cycle recorded outputs
  logic         r_mem_req [MAXC];
  logic         r_iord    [MAXC];
  logic         r_irw     [MAXC];
  logic         r_pcw     [MAXC];
  logic         r_pc_en   [MAXC];
  logic [1:0]   r_pc_src  [MAXC];
  logic [1:0]   r_srcb    [MAXC];
  logic [1:0]   r_aluop   [MAXC];
  logic         r_regw    [MAXC];
  logic         r_regdst  [MAXC];
  logic         r_m2r     [MAXC];
  logic         r_memw    [MAXC];
  logic         r_done    [MAXC];
  int unsigned  done_cnt;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Run n cycles from the tables, checking state each cycle and recording outputs
  task automatic walk(input string tag, input int n);
    done_cnt = 0;
    for (int i = 0; i < n; i++) begin
      bus.mem_ready = rdy_seq[i];
      bus.opcode    = op_seq[i];
      #1;
      check_eq($sformatf("%s_state_c%0d", tag, i), int'(bus.state), exp_state[i]);
      r_mem_req[i] = bus.mem_req;
      r_iord[i]    = bus.iord;
      r_irw[i]     = bus.ir_write;
      r_pcw[i]     = bus.pc_write;
      r_pc_en[i]   = bus.pc_en;
      r_pc_src[i]  = bus.pc_src;
      r_srcb[i]    = bus.alu_src_b;
      r_aluop[i]   = bus.alu_op;
      r_regw[i]    = bus.reg_write;
      r_regdst[i]  = bus.reg_dest;
      r_m2r[i]     = bus.mem_to_reg;
      r_memw[i]    = bus.mem_write;
      r_done[i]    = bus.instr_done;
      done_cnt     = done_cnt + int'(bus.instr_done);
      cyc();
    end
  endtask

  // Fill tables for an instruction with mem_ready held high
  task automatic plan(input logic [5:0] op, input int n, input int unsigned s0, input int unsigned s1,
                      input int unsigned s2, input int unsigned s3, input int unsigned s4);
    int unsigned s [5];
    s = '{s0, s1, s2, s3, s4};
    for (int i = 0; i < MAXC; i++) begin
      rdy_seq[i]   = 1'b1;
      op_seq[i]    = op;
      exp_state[i] = (i < 5) ? s[i] : 0;
    end
    if (n > 5) $fatal(1, "FAIL plan: sequence too long");
  endtask

  initial begin
    bus.opcode    = OP_RTYPE;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b1;
    rst           = 1'b1;

    // Reset: outputs forced low even though state decodes as FETCH
    cyc(); cyc();
    check_eq("rst_mem_req", bus.mem_req, 0);
    check_eq("rst_ir_write", bus.ir_write, 0);
    check_eq("rst_pc_en", bus.pc_en, 0);
    check_eq("rst_state", int'(bus.state), 0);
    rst = 1'b0;

    // LW, ready high: 0,1,2,3,4
    plan(OP_LW, 5, 0, 1, 2, 3, 4);
    walk("lw", 5);
    check_eq("lw_fetch_mem_req", r_mem_req[0], 1);
    check_eq("lw_fetch_ir_write", r_irw[0], 1);
    check_eq("lw_memadr_srcb", r_srcb[2], 2);
    check_eq("lw_memread_iord", r_iord[3], 1);
    check_eq("lw_wb_reg_write", r_regw[4], 1);
    check_eq("lw_wb_mem_to_reg", r_m2r[4], 1);
    check_eq("lw_wb_reg_dest", r_regdst[4], 0);
    check_eq("lw_done_pulses", done_cnt, 1);

    // SW with two stall cycles in MEMWR; opcode changes during stall are ignored
    plan(OP_SW, 5, 0, 1, 2, 5, 5);
    exp_state[5] = 5;
    rdy_seq[3] = 1'b0; rdy_seq[4] = 1'b0; rdy_seq[5] = 1'b1;
    op_seq[3] = OP_LW; op_seq[4] = OP_BEQ; op_seq[5] = OP_LW;
    walk("sw", 6);
    for (int i = 3; i < 6; i++) begin
      check_eq($sformatf("sw_mem_write_c%0d", i), r_memw[i], 1);
      check_eq($sformatf("sw_done_c%0d", i), r_done[i], (i == 5) ? 1 : 0);
    end
    check_eq("sw_done_pulses", done_cnt, 1);

    // FETCH stall 3 cycles then ADDI: 0,0,0,0,1,9,10
    plan(OP_ADDI, 5, 0, 0, 0, 0, 1);
    exp_state[5] = 9; exp_state[6] = 10;
    rdy_seq[0] = 1'b0; rdy_seq[1] = 1'b0; rdy_seq[2] = 1'b0;
    walk("fstall", 7);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("fstall_ir_write_c%0d", i), r_irw[i], (i == 3) ? 1 : 0);
      check_eq($sformatf("fstall_pc_write_c%0d", i), r_pcw[i], (i == 3) ? 1 : 0);
      check_eq($sformatf("fstall_mem_req_c%0d", i), r_mem_req[i], 1);
    end
    check_eq("addi_ex_srcb", r_srcb[5], 2);
    check_eq("addi_wb_reg_write", r_regw[6], 1);
    check_eq("addi_wb_reg_dest", r_regdst[6], 0);
    check_eq("addi_wb_mem_to_reg", r_m2r[6], 0);

    // BEQ taken: zero high throughout; DECODE must not see pc_en
    bus.zero = 1'b1;
    plan(OP_BEQ, 3, 8'd0, 1, 8, 0, 0);
    walk("beq_t", 3);
    check_eq("beq_t_decode_pc_en", r_pc_en[1], 0);
    check_eq("beq_t_pc_en", r_pc_en[2], 1);
    check_eq("beq_t_pc_src", r_pc_src[2], 1);
    check_eq("beq_t_alu_op", r_aluop[2], 1);
    check_eq("beq_t_done", r_done[2], 1);

    // BEQ not taken
    bus.zero = 1'b0;
    plan(OP_BEQ, 3, 0, 1, 8, 0, 0);
    walk("beq_n", 3);
    check_eq("beq_n_pc_en", r_pc_en[2], 0);
    check_eq("beq_n_pc_src", r_pc_src[2], 1);

    // J
    plan(OP_JUMP, 3, 0, 1, 11, 0, 0);
    walk("j", 3);
    check_eq("j_pc_src", r_pc_src[2], 2);
    check_eq("j_pc_en", r_pc_en[2], 1);
    check_eq("j_done_pulses", done_cnt, 1);

    // Unknown opcode follows the RTYPE path
    plan(6'h3f, 4, 0, 1, 6, 7, 0);
    walk("unk", 4);
    check_eq("unk_ex_alu_op", r_aluop[2], 2);
    check_eq("unk_ex_srcb", r_srcb[2], 0);
    check_eq("unk_wb_reg_dest", r_regdst[3], 1);
    check_eq("unk_wb_reg_write", r_regw[3], 1);

    // Reset while stalled in MEMREAD: 0,1,2,3 with ready low at MEMREAD
    plan(OP_LW, 4, 0, 1, 2, 3, 0);
    rdy_seq[3] = 1'b0;
    walk("rstmr", 4);
    check_eq("rstmr_pre_state", int'(bus.state), 3);
    rst = 1'b1;
    bus.mem_ready = 1'b1;  // would complete the read if reset were ignored
    for (int i = 0; i < 2; i++) begin
      #1;
      check_eq($sformatf("rstmr_hold_mem_req_c%0d", i), bus.mem_req, 0);
      check_eq($sformatf("rstmr_hold_iord_c%0d", i), bus.iord, 0);
      check_eq($sformatf("rstmr_hold_reg_write_c%0d", i), bus.reg_write, 0);
      cyc();
    end
    rst = 1'b0;
    #1;
    check_eq("rstmr_rel_state", int'(bus.state), 0);
    check_eq("rstmr_rel_mem_req", bus.mem_req, 1);
    check_eq("rstmr_rel_reg_write", bus.reg_write, 0);
    cyc();
    #1;
    check_eq("rstmr_next_state", int'(bus.state), 1);
    check_eq("rstmr_next_reg_write", bus.reg_write, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Absolute time bound so the bench cannot hang
  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
